// File: rtl/pc_predict_unit_if.sv
// Fetch-side bundle of the PC predictor: IF handshake, redirect request,
// branch-resolution update and the predicted fetch PC.
// master = the PC predictor, slave = the fetch/branch logic around it.
interface pc_predict_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  if_ready_in;
  logic                  redirect_in;
  logic [ADDR_WIDTH-1:0] redirect_addr_in;
  logic                  bu_valid_in;
  logic [ADDR_WIDTH-1:0] bu_pc_in;
  logic [ADDR_WIDTH-1:0] bu_target_in;
  logic                  bu_taken_in;
  logic [ADDR_WIDTH-1:0] pc_out;
  logic                  pc_valid_out;
  logic                  pred_taken_out;
  logic [ADDR_WIDTH-1:0] pred_target_out;

  modport master (
    input  if_ready_in, redirect_in, redirect_addr_in,
           bu_valid_in, bu_pc_in, bu_target_in, bu_taken_in,
    output pc_out, pc_valid_out, pred_taken_out, pred_target_out
  );

  modport slave (
    output if_ready_in, redirect_in, redirect_addr_in,
           bu_valid_in, bu_pc_in, bu_target_in, bu_taken_in,
    input  pc_out, pc_valid_out, pred_taken_out, pred_target_out
  );
endinterface

// File: rtl/pc_predict_unit.sv
// Fetch PC generator with priority redirect, redirect stretching across
// rdy_in-low periods, and an optional direct-mapped BTB with 2-bit counters.
// Optional BTB: define PC_PREDICT_BTB_EN to build it; without it the unit
// always predicts pc_out+4 and ignores branch updates.
module pc_predict_unit #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    BTB_ENTRIES = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input logic                  clk_in,
  input logic                  rst_in,
  input logic                  rdy_in,
  pc_predict_unit_if.master    bus
);

  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = ADDR_WIDTH - IDX - 2;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  pc_valid_q, pc_valid_d;
  logic                  pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;

  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [ADDR_WIDTH-1:0] redirect_aligned;
  logic                  accept;
  logic                  pred_taken;
  logic [ADDR_WIDTH-1:0] pred_target;

  assign pc_plus4         = pc_q + ADDR_WIDTH'(4);
  assign redirect_aligned = {bus.redirect_addr_in[ADDR_WIDTH-1:2], 2'b00};
  assign accept           = pc_valid_q & bus.if_ready_in & rdy_in;

  // Next fetch PC: live redirect > pending redirect > accept > hold
  always_comb begin
    pc_d        = pc_q;
    pc_valid_d  = pc_valid_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    if (rdy_in) begin
      pc_valid_d = 1'b1;
      pend_d     = 1'b0;
      if (bus.redirect_in) begin
        pc_d = redirect_aligned;
      end else if (pend_q) begin
        pc_d = pend_addr_q;
      end else if (accept) begin
        pc_d = pred_target;
      end
    end else if (bus.redirect_in) begin
      // Stall: remember the most recent redirect until rdy_in returns
      pend_d      = 1'b1;
      pend_addr_d = redirect_aligned;
    end
  end

  // PC, valid and pending-redirect registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pc_q        <= RESET_PC;
      pc_valid_q  <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      pc_q        <= pc_d;
      pc_valid_q  <= pc_valid_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
    end
  end

`ifdef PC_PREDICT_BTB_EN
  logic [BTB_ENTRIES-1:0]            btb_valid;
  logic [BTB_ENTRIES-1:0][TAG_W-1:0] btb_tag;
  logic [BTB_ENTRIES-1:0][ADDR_WIDTH-1:0] btb_tgt;
  logic [BTB_ENTRIES-1:0][1:0]       btb_cnt;

  logic [IDX-1:0]   lk_idx, bu_idx;
  logic [TAG_W-1:0] lk_tag, bu_tag;
  logic             lk_hit, bu_hit, bu_en;
  logic             unused_bits;

  assign lk_idx = pc_q[IDX+1:2];
  assign lk_tag = pc_q[ADDR_WIDTH-1:IDX+2];
  assign lk_hit = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);

  // Lookup sees the registered entry, so a same-cycle update shows up next cycle
  assign pred_taken  = lk_hit & btb_cnt[lk_idx][1];
  assign pred_target = pred_taken ? btb_tgt[lk_idx] : pc_plus4;

  assign bu_idx = bus.bu_pc_in[IDX+1:2];
  assign bu_tag = bus.bu_pc_in[ADDR_WIDTH-1:IDX+2];
  assign bu_hit = btb_valid[bu_idx] && (btb_tag[bu_idx] == bu_tag);
  assign bu_en  = bus.bu_valid_in & rdy_in;

  assign unused_bits = ^{bus.redirect_addr_in[1:0], bus.bu_pc_in[1:0]};

  for (genvar gi = 0; gi < BTB_ENTRIES; gi++) begin : g_btb
    logic                  v_q, v_d;
    logic [TAG_W-1:0]      tag_q, tag_d;
    logic [ADDR_WIDTH-1:0] tgt_q, tgt_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  sel;

    assign sel = bu_en && (bu_idx == IDX'(gi));

    // Counter training on a hit, allocation on a taken miss
    always_comb begin
      v_d   = v_q;
      tag_d = tag_q;
      tgt_d = tgt_q;
      cnt_d = cnt_q;
      if (sel) begin
        if (bu_hit) begin
          if (bus.bu_taken_in) begin
            cnt_d = (cnt_q == 2'd3) ? 2'd3 : cnt_q + 2'd1;
            tgt_d = bus.bu_target_in;
          end else begin
            cnt_d = (cnt_q == 2'd0) ? 2'd0 : cnt_q - 2'd1;
          end
        end else if (bus.bu_taken_in) begin
          v_d   = 1'b1;
          tag_d = bu_tag;
          tgt_d = bus.bu_target_in;
          cnt_d = 2'd2;
        end
      end
    end

    // Entry storage; reset leaves every entry invalid and strongly not-taken
    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
        v_q   <= 1'b0;
        tag_q <= '0;
        tgt_q <= '0;
        cnt_q <= 2'd0;
      end else begin
        v_q   <= v_d;
        tag_q <= tag_d;
        tgt_q <= tgt_d;
        cnt_q <= cnt_d;
      end
    end

    assign btb_valid[gi] = v_q;
    assign btb_tag[gi]   = tag_q;
    assign btb_tgt[gi]   = tgt_q;
    assign btb_cnt[gi]   = cnt_q;
  end
`else
  logic unused_bits;

  assign pred_taken  = 1'b0;
  assign pred_target = pc_plus4;
  assign unused_bits = ^{bus.redirect_addr_in[1:0], bus.bu_valid_in, bus.bu_pc_in,
                         bus.bu_target_in, bus.bu_taken_in};
`endif

  assign bus.pc_out          = pc_q;
  assign bus.pc_valid_out    = pc_valid_q;
  assign bus.pred_taken_out  = pred_taken;
  assign bus.pred_target_out = pred_target;

endmodule

// File: tb/tb_pc_predict_unit.sv
// Self-checking bench for pc_predict_unit: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_pc_predict_unit;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b0;

  pc_predict_unit_if #(.ADDR_WIDTH(AW)) bus();

  pc_predict_unit #(
    .ADDR_WIDTH (AW),
    .BTB_ENTRIES(16),
    .RESET_PC   (32'h0)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .rdy_in(rdy),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  // Behavioural model state
  logic [31:0] m_pc, m_pend_addr;
  bit          m_valid, m_pend;
  typedef struct {
    bit          v;
    logic [31:0] tag;
    logic [31:0] tgt;
    int          cnt;
  } ent_t;
  ent_t m_btb[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_hit(input logic [31:0] pc);
    int i;
    i = int'((pc >> 2) & 32'hF);
    return m_btb[i].v && (m_btb[i].tag == (pc >> 6));
  endfunction

  function automatic bit m_pred_taken();
`ifdef PC_PREDICT_BTB_EN
    return m_hit(m_pc) && (m_btb[int'((m_pc >> 2) & 32'hF)].cnt >= 2);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_pred_target();
    if (m_pred_taken()) return m_btb[int'((m_pc >> 2) & 32'hF)].tgt;
    return m_pc + 32'd4;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_valid = 0; m_pend = 0; m_pend_addr = 0;
    for (int i = 0; i < 16; i++) begin
      m_btb[i].v = 0; m_btb[i].tag = 0; m_btb[i].tgt = 0; m_btb[i].cnt = 0;
    end
  endtask

  task automatic model_btb_update();
    int  i;
    bit  h;
    i = int'((bus.bu_pc_in >> 2) & 32'hF);
    h = m_hit(bus.bu_pc_in);
    if (h) begin
      if (bus.bu_taken_in) begin
        m_btb[i].cnt = (m_btb[i].cnt >= 3) ? 3 : m_btb[i].cnt + 1;
        m_btb[i].tgt = bus.bu_target_in;
      end else begin
        m_btb[i].cnt = (m_btb[i].cnt <= 0) ? 0 : m_btb[i].cnt - 1;
      end
    end else if (bus.bu_taken_in) begin
      m_btb[i].v = 1; m_btb[i].tag = bus.bu_pc_in >> 6;
      m_btb[i].tgt = bus.bu_target_in; m_btb[i].cnt = 2;
    end
  endtask

  // Advance the model by one rising edge using the inputs held during it
  task automatic model_step();
    logic [31:0] pt;
    bit          acc;
    if (rst) begin
      model_reset();
      return;
    end
    pt  = m_pred_target();
    acc = m_valid && bus.if_ready_in && rdy;
    if (rdy) begin
      if (bus.redirect_in) begin
        m_pc = bus.redirect_addr_in & ~32'h3; m_pend = 0;
      end else if (m_pend) begin
        m_pc = m_pend_addr; m_pend = 0;
      end else if (acc) begin
        m_pc = pt;
      end
      m_valid = 1;
`ifdef PC_PREDICT_BTB_EN
      if (bus.bu_valid_in) model_btb_update();
`endif
    end else if (bus.redirect_in) begin
      m_pend = 1; m_pend_addr = bus.redirect_addr_in & ~32'h3;
    end
  endtask

  // Compare DUT outputs with the model every cycle
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("pc_out", bus.pc_out, m_pc);
      chk("pc_valid_out", {31'b0, bus.pc_valid_out}, {31'b0, m_valid});
      chk("pred_taken_out", {31'b0, bus.pred_taken_out}, {31'b0, m_pred_taken()});
      chk("pred_target_out", bus.pred_target_out, m_pred_target());
    end
  end

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] base;
    base = ($urandom % 2 == 0) ? 32'h0 : 32'h0001_0000;
    return base | (($urandom % 64) << 2) | ($urandom % 4);
  endfunction

  initial begin
    bus.if_ready_in = 0; bus.redirect_in = 0; bus.redirect_addr_in = 0;
    bus.bu_valid_in = 0; bus.bu_pc_in = 0; bus.bu_target_in = 0; bus.bu_taken_in = 0;
    model_reset();
    cmp_en = 1'b1;
    #1;
    chk("reset_pc", bus.pc_out, 32'h0);
    chk("reset_valid", {31'b0, bus.pc_valid_out}, 32'h0);

    // Reset release and straight-line fetch
    @(negedge clk);
    rst = 0; rdy = 1; bus.if_ready_in = 1;
    cycle(); chk("valid_rise", {31'b0, bus.pc_valid_out}, 32'h1); chk("seq0", bus.pc_out, 32'h0);
    cycle(); chk("seq1", bus.pc_out, 32'h4);
    cycle(); chk("seq2", bus.pc_out, 32'h8);

    // IF back-pressure
    bus.if_ready_in = 0;
    repeat (3) begin cycle(); chk("hold", bus.pc_out, 32'h8); end
    bus.if_ready_in = 1;
    cycle(); chk("resume", bus.pc_out, 32'hC);
    cycle(); chk("seq4", bus.pc_out, 32'h10);

    // Redirect beats simultaneous accept, low bits forced to zero
    bus.redirect_in = 1; bus.redirect_addr_in = 32'h1002;
    cycle(); bus.redirect_in = 0;
    chk("redir_vs_accept", bus.pc_out, 32'h1000);

    // Redirects while stalled: last one wins, applied one cycle after rdy rises
    rdy = 0; bus.redirect_in = 1; bus.redirect_addr_in = 32'h200;
    cycle(); bus.redirect_in = 0; chk("stall_freeze0", bus.pc_out, 32'h1000);
    cycle(); chk("stall_freeze1", bus.pc_out, 32'h1000);
    bus.redirect_in = 1; bus.redirect_addr_in = 32'h300;
    cycle(); bus.redirect_in = 0; chk("stall_freeze2", bus.pc_out, 32'h1000);
    rdy = 1;
    cycle(); chk("pending_apply", bus.pc_out, 32'h300);
    cycle(); chk("after_pending", bus.pc_out, 32'h304);

    // Wrap-around of pc+4
    bus.redirect_in = 1; bus.redirect_addr_in = 32'hFFFF_FFFC;
    cycle(); bus.redirect_in = 0; chk("wrap_pre", bus.pc_out, 32'hFFFF_FFFC);
    cycle(); chk("wrap", bus.pc_out, 32'h0);

    // BTB allocate, predict, then train down to not-taken
    bus.redirect_in = 1; bus.redirect_addr_in = 32'h40;
    bus.bu_valid_in = 1; bus.bu_pc_in = 32'h40; bus.bu_target_in = 32'h80; bus.bu_taken_in = 1;
    cycle(); bus.redirect_in = 0; bus.bu_valid_in = 0;
    chk("btb_pc", bus.pc_out, 32'h40);
`ifdef PC_PREDICT_BTB_EN
    chk("btb_taken", {31'b0, bus.pred_taken_out}, 32'h1);
    chk("btb_target", bus.pred_target_out, 32'h80);
    cycle(); chk("btb_follow", bus.pc_out, 32'h80);
`else
    chk("nobtb_taken", {31'b0, bus.pred_taken_out}, 32'h0);
    chk("nobtb_target", bus.pred_target_out, 32'h44);
    cycle(); chk("nobtb_follow", bus.pc_out, 32'h44);
`endif
    bus.bu_valid_in = 1; bus.bu_pc_in = 32'h40; bus.bu_taken_in = 0;
    cycle(); cycle();
    bus.bu_valid_in = 0; bus.redirect_in = 1; bus.redirect_addr_in = 32'h40;
    cycle(); bus.redirect_in = 0;
    chk("trained_taken", {31'b0, bus.pred_taken_out}, 32'h0);
    chk("trained_target", bus.pred_target_out, 32'h44);

    // Randomized traffic with a mid-stream asynchronous reset
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        @(posedge clk);
        #2 rst = 1;
        #1;
        chk("async_rst_pc", bus.pc_out, 32'h0);
        chk("async_rst_valid", {31'b0, bus.pc_valid_out}, 32'h0);
        model_reset();
        @(negedge clk);
        cycle();
        rst = 0;
      end
      rdy                  = ($urandom % 8) != 0;
      bus.if_ready_in      = ($urandom % 4) != 0;
      bus.redirect_in      = ($urandom % 10) == 0;
      bus.redirect_addr_in = rand_addr();
      bus.bu_valid_in      = ($urandom % 3) == 0;
      bus.bu_pc_in         = ($urandom % 2 == 0) ? m_pc : rand_addr();
      bus.bu_target_in     = rand_addr() & ~32'h3;
      bus.bu_taken_in      = ($urandom % 3) != 0;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_predict_unit.md
Name: pc_predict_unit

Overview:
Parametrised program-counter generator for the RISC-V core, feeding the instruction-fetch stage. It holds the fetch PC and offers it to IF through a valid/ready handshake. On each accept it advances to a predicted next PC. It takes a priority redirect from the branch/commit logic, and it stretches a redirect that arrives while the memory system is not ready. An optional direct-mapped branch target buffer (BTB) with 2-bit counters supplies taken predictions.

Parameters:
ADDR_WIDTH, 32, PC width in bits.
BTB_ENTRIES, 16, BTB entry count; power of 2, at least 2; IDX = log2(BTB_ENTRIES).
RESET_PC, 0, PC value loaded on reset.

Ports:
clk_in  input  1  clock; all state updates on the rising edge.
rst_in  input  1  asynchronous, active-high reset.
rdy_in  input  1  global ready; when low, all state is frozen except the pending-redirect latch.
if_ready_in  input  1  IF can take pc_out this cycle.
redirect_in  input  1  one-cycle pulse; fetch must restart at redirect_addr_in.
redirect_addr_in  input  ADDR_WIDTH  redirect target.
bu_valid_in  input  1  resolved branch update valid.
bu_pc_in  input  ADDR_WIDTH  PC of the resolved branch.
bu_target_in  input  ADDR_WIDTH  resolved target.
bu_taken_in  input  1  resolved direction.
pc_out  output  ADDR_WIDTH  current fetch PC (registered).
pc_valid_out  output  1  pc_out offered to IF (registered).
pred_taken_out  output  1  prediction for pc_out (combinational from registered state).
pred_target_out  output  ADDR_WIDTH  predicted next PC for pc_out.

Behaviour:
- Reset (rst_in high, asynchronous, any cycle including mid-operation):
  - pc_out=RESET_PC, pc_valid_out=0, pending redirect cleared.
  - All BTB valid bits=0 and counters=0 (weakly not-taken minus one, i.e. strong not-taken).
- First rising edge with rst_in low and rdy_in high: pc_valid_out=1. It stays 1 thereafter; no bubble is inserted on redirect.
- accept = pc_valid_out & if_ready_in & rdy_in.
- Next-PC priority, evaluated on each edge with rdy_in high:
  1. effective redirect (redirect_in, or pending latch set): pc_out <= redirect address with bits[1:0] forced to 0. Pending is cleared. A simultaneous accept is discarded.
  2. accept: pc_out <= pred_target_out.
  3. otherwise: hold pc_out.
- When redirect_in and the pending latch are both set, the live redirect_in address wins.
- redirect_in while rdy_in low:
  - Captured into the pending latch (address and flag).
  - A later redirect, still while rdy_in is low, overwrites the latch.
  - Applied on the first edge with rdy_in high. Latency from rdy_in rising to the new pc_out is 1 cycle.
- Arithmetic: pc_out+4 is modulo 2^ADDR_WIDTH; 0xFFFFFFFC wraps to 0x00000000.
- BTB organisation:
  - index = pc[IDX+1:2]; tag = pc[ADDR_WIDTH-1:IDX+2].
  - Each entry holds a valid bit, tag, target and a 2-bit saturating counter.
- Lookup: hit = valid & tag match on pc_out.
  - pred_taken_out = hit & counter>=2.
  - pred_target_out = pred_taken_out ? stored target : pc_out+4.
- Update on bu_valid_in & rdy_in:
  - Hit on bu_pc_in: counter +1 (saturate at 3) if taken, else -1 (saturate at 0). Target is rewritten when taken.
  - Miss and taken: allocate (overwrite) the entry with valid=1, new tag, bu_target_in, counter=2.
  - Miss and not taken: no change.
- Update and lookup in the same cycle to the same index: the lookup uses the pre-update contents; the new contents are visible on the next cycle.
- Redirect and update in the same cycle are independent; both take effect.

Optional Feature:
PC_PREDICT_BTB_EN
- Defined: BTB built as described above.
- Undefined:
  - No BTB storage.
  - pred_taken_out=0 and pred_target_out=pc_out+4 always.
  - bu_* inputs ignored.
  - Handshake and redirect behaviour unchanged.

Test Plan:
- Reset, RESET_PC=0x0, rdy_in=1, if_ready_in=1 for 4 cycles -> pc_valid_out rises 1 cycle after reset release; pc_out sequence 0x0, 0x4, 0x8, 0xC.
- if_ready_in=0 for 3 cycles at pc_out=0x8 -> pc_out holds 0x8; resumes at 0xC the cycle after if_ready_in=1.
- redirect_in with addr 0x1002 in the same cycle as accept at pc_out=0x10 -> next pc_out=0x1000, not 0x14.
- rdy_in=0; redirect to 0x200, then redirect to 0x300 two cycles later; rdy_in=1 -> pc_out=0x300 one cycle after rdy_in rises. Check that 0x200 is never presented.
- BTB enabled: bu update (pc 0x40, target 0x80, taken) -> next fetch of 0x40 gives pred_taken_out=1 and next pc_out 0x80. Two not-taken updates drop the counter to 0 -> prediction falls back to 0x44.
- pc_out=0xFFFFFFFC accepted with no BTB hit -> pc_out=0x00000000. Assert rst_in mid-stream asynchronously -> pc_out=RESET_PC and pc_valid_out=0 immediately, without waiting for a clock edge.
